ps2_receiver: RTL

//  Deserialises the PS/2 keyboard line (ps2_clk/ps2_data, device-driven) into 8-bit scan codes.

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 55 +++++
 rtl/ps2_receiver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and frame constants.
// Imported by the receiver and the key-memory stage.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

  localparam logic       PS2_START_BIT = 1'b0;
  localparam logic       PS2_STOP_BIT  = 1'b1;
  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED  = 8'hE0;

  // Odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic ps2_parity_ok(
    input logic [7:0] b,
    input logic       p
  );
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser, stability filter and falling-edge strobe
// for one asynchronous PS/2 line.
module ps2_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_fall;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_fall = r_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
    end
  end

  // The filtered level only follows a run of
  // FILTER_LEN consecutive samples at the new level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt <= 1'b1;
      r_cnt  <= '0;
      r_fall <= 1'b0;
    end else begin
      r_fall <= 1'b0;
      if (w_sync == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
        r_fall <= ~w_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: frames ps2_clk/ps2_data into
// checked 8-bit scan codes with error pulses.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scanCode,
  output logic       scanCodeReady,
  output logic       parityError,
  output logic       frameError
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX =
    TW'(TIMEOUT_CYCLES);

  ps2_rx_state_t          r_state;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [7:0]             r_shift;
  logic [2:0]             r_bitcnt;
  logic                   r_parity;
  logic [TW-1:0]          r_tmo;
  logic [7:0]             r_code;
  logic                   r_ready;
  logic                   r_perr;
  logic                   r_ferr;
  logic                   w_fall;
  logic                   w_data;
  logic                   w_timeout;

  ps2_line_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rst    (rst),
    .i_line (ps2_clk),
    .o_fall (w_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_sync <= '1;
    end else begin
      r_data_sync <=
        {r_data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign w_data    = r_data_sync[SYNC_STAGES-1];
  assign w_timeout = (r_state != IDLE) &&
                     (r_tmo == TMO_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_parity <= 1'b0;
      r_tmo    <= '0;
      r_code   <= '0;
      r_ready  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;

      if (w_fall || r_state == IDLE) begin
        r_tmo <= '0;
      end else if (r_tmo != TMO_MAX) begin
        r_tmo <= r_tmo + 1'b1;
      end

      if (w_fall) begin
        unique case (r_state)
          IDLE: begin
            if (w_data == PS2_START_BIT) begin
              r_state  <= DATA;
              r_shift  <= '0;
              r_bitcnt <= '0;
            end
          end
          DATA: begin
            r_shift <= {w_data, r_shift[7:1]};
            if (r_bitcnt == 3'd7) begin
              r_bitcnt <= '0;
              r_state  <= PARITY;
            end else begin
              r_bitcnt <= r_bitcnt + 3'd1;
            end
          end
          PARITY: begin
            r_parity <= w_data;
            r_state  <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            // A bad stop bit outranks a parity failure.
            if (w_data != PS2_STOP_BIT) begin
              r_ferr <= 1'b1;
            end else if (ps2_parity_ok(r_shift,
                                       r_parity)) begin
              r_code  <= r_shift;
              r_ready <= 1'b1;
            end else begin
              r_perr <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_timeout) begin
        r_state  <= IDLE;
        r_shift  <= '0;
        r_bitcnt <= '0;
        r_tmo    <= '0;
        r_ferr   <= 1'b1;
      end
    end
  end

  assign scanCode      = r_code;
  assign scanCodeReady = r_ready;
  assign parityError   = r_perr;
  assign frameError    = r_ferr;

endmodule
